// File: rtl/upcounter_checker.sv
// Purpose : passive in-fabric checker for a 4-bit up counter with load; flags
//           cycles where the counter output differs from a reference model.
// Latency : controls sampled at edge k are checked against data sampled at
//           edge k+1; all results are registered and visible after edge k+1.
// Backpressure: none. The checker only observes and never stalls the counter.
//
// Ports:
//   clk          - clock shared with the monitored counter
//   rst          - synchronous active-low reset of the checker
//   mon_rst      - counter's synchronous active-low reset input (observed)
//   mon_load     - counter's load enable (observed)
//   mon_data_in  - counter's load value (observed)
//   mon_data_out - counter's registered output (observed)
//   synced       - reference model valid, comparisons active
//   err          - one-cycle pulse per mismatching sample
//   err_sticky   - set on the first mismatch, cleared only by rst
//   err_cnt      - saturating mismatch count
//   wrap_cnt     - wrapping count of 15->0 increment transitions
//   first_exp    - predicted value at the first mismatch
//   first_act    - observed value at the first mismatch
//   halted       - checker stopped after a mismatch (STOP_ON_ERR=1 only)

module upcounter_checker #(
  parameter int ERR_CNT_W   = 8,
  parameter int WRAP_CNT_W  = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mon_rst,
  input  logic                  mon_load,
  input  logic [3:0]            mon_data_in,
  input  logic [3:0]            mon_data_out,
  output logic                  synced,
  output logic                  err,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic [3:0]            first_exp,
  output logic [3:0]            first_act,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_CHECK  = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0]  ERR_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0]  ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [WRAP_CNT_W-1:0] WRAP_ONE = {{(WRAP_CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_nxt;

  logic [3:0]            r_exp;
  logic                  r_exp_valid;
  logic                  r_err;
  logic                  r_err_sticky;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [WRAP_CNT_W-1:0] r_wrap_cnt;
  logic [3:0]            r_first_exp;
  logic [3:0]            r_first_act;
  logic                  r_wrap_arm;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [3:0] w_pred;
  logic       w_seed;
  logic       w_cmp_en;
  logic       w_mismatch;
  logic       w_wrap;
  logic       w_wrap_arm_nxt;
  logic       w_exp_upd;

  // Counter value after this edge. The increment path is built on the
  // observed output rather than on r_exp, so after a fault the model
  // follows the real counter and a single glitch costs a single error.
  always_comb begin
    w_pred = 4'd0;
    if (!mon_rst) begin
      w_pred = 4'd0;
    end else if (mon_load) begin
      w_pred = mon_data_in;
    end else begin
      w_pred = mon_data_out + 4'd1;
    end
  end

  // A reset or load fully determines the next counter value regardless of
  // what the counter held before, so either one can seed the model.
  assign w_seed = !mon_rst || mon_load;

  assign w_cmp_en   = (r_state == ST_CHECK) && r_exp_valid;
  assign w_mismatch = w_cmp_en && (mon_data_out != r_exp);

  // Arm when a plain increment is requested from 15; the wrap is confirmed
  // on the next sample if it reads 0 and matched the model. Reset-driven
  // 15->0 transitions never arm because mon_rst must be high here.
  assign w_wrap_arm_nxt = (r_state == ST_CHECK) && (mon_data_out == 4'hF) &&
                          mon_rst && !mon_load;
  assign w_wrap = w_cmp_en && r_wrap_arm && (mon_data_out == 4'd0) &&
                  !w_mismatch;

  // r_exp is reloaded on the edge that leaves UNSYNC and on every CHECK
  // edge; it is left alone in HALT.
  assign w_exp_upd = ((r_state == ST_UNSYNC) && w_seed) ||
                     (r_state == ST_CHECK);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_UNSYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_UNSYNC: begin
        if (w_seed) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_mismatch && STOP_ON_ERR) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // Only rst leaves HALT.
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_UNSYNC;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    synced = 1'b0;
    halted = 1'b0;
    unique case (r_state)
      ST_UNSYNC: begin
        synced = 1'b0;
        halted = 1'b0;
      end
      ST_CHECK: begin
        synced = 1'b1;
        halted = 1'b0;
      end
      ST_HALT: begin
        synced = 1'b0;
        halted = 1'b1;
      end
      default: begin
        synced = 1'b0;
        halted = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reference model register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_exp       <= 4'd0;
      r_exp_valid <= 1'b0;
    end else begin
      if (w_exp_upd) begin
        r_exp <= w_pred;
      end
      r_exp_valid <= (w_state_nxt == ST_CHECK);
    end
  end

  // ---------------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_first_exp  <= 4'd0;
      r_first_act  <= 4'd0;
    end else begin
      // w_mismatch is already gated by CHECK, so everything here freezes in
      // HALT and UNSYNC without extra qualification.
      r_err <= w_mismatch;
      if (w_mismatch) begin
        r_err_sticky <= 1'b1;
        if (r_err_cnt != ERR_MAX) begin
          r_err_cnt <= r_err_cnt + ERR_ONE;
        end
        if (!r_err_sticky) begin
          r_first_exp <= r_exp;
          r_first_act <= mon_data_out;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Wrap-event tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrap_arm <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      r_wrap_arm <= w_wrap_arm_nxt;
      if (w_wrap) begin
        r_wrap_cnt <= r_wrap_cnt + WRAP_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;
  assign wrap_cnt   = r_wrap_cnt;
  assign first_exp  = r_first_exp;
  assign first_act  = r_first_act;

endmodule

// File: tb/tb_upcounter_checker.sv
// Bench for upcounter_checker: the bench plays the monitored counter and
// drives its controls and output directly, injecting faults where wanted.
// Two instances: default (STOP_ON_ERR=0) and a halting one (STOP_ON_ERR=1).

module tb_upcounter_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       mon_rst;
  logic       mon_load;
  logic [3:0] mon_data_in;
  logic [3:0] mon_data_out;

  logic       synced, err, err_sticky, halted;
  logic [7:0] err_cnt, wrap_cnt;
  logic [3:0] first_exp, first_act;

  logic       h_synced, h_err, h_err_sticky, h_halted;
  logic [7:0] h_err_cnt, h_wrap_cnt;
  logic [3:0] h_first_exp, h_first_act;

  int tests_run = 0;
  int fails     = 0;
  int exp_wrap  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  upcounter_checker #(.ERR_CNT_W(8), .WRAP_CNT_W(8), .STOP_ON_ERR(1'b0)) dut (
    .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_load(mon_load),
    .mon_data_in(mon_data_in), .mon_data_out(mon_data_out),
    .synced(synced), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt), .first_exp(first_exp), .first_act(first_act),
    .halted(halted)
  );

  upcounter_checker #(.ERR_CNT_W(8), .WRAP_CNT_W(8), .STOP_ON_ERR(1'b1)) dut_h (
    .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_load(mon_load),
    .mon_data_in(mon_data_in), .mon_data_out(mon_data_out),
    .synced(h_synced), .err(h_err), .err_sticky(h_err_sticky), .err_cnt(h_err_cnt),
    .wrap_cnt(h_wrap_cnt), .first_exp(h_first_exp), .first_act(h_first_act),
    .halted(h_halted)
  );

  // Drive one sample, record the err value the default instance must show
  // after this edge, then move 1 time unit past the edge.
  task automatic step(input logic r, input logic mr, input logic ml,
                      input logic [3:0] din, input logic [3:0] dout, input logic e);
    rst          = r;
    mon_rst      = mr;
    mon_load     = ml;
    mon_data_in  = din;
    mon_data_out = dout;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic pop_exp();
    if (exp_q.size() == 0) return 1'bx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    logic e;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 4'($urandom_range(15)), 1'b0);
      e = pop_exp();
      tests_run++; if (err !== e) begin fails++; $display("FAIL reset_err got=%b exp=%b", err, e); end
      tests_run++; if (synced !== 1'b0) begin fails++; $display("FAIL reset_synced got=%b exp=0", synced); end
      tests_run++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      tests_run++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
      tests_run++; if (wrap_cnt !== 8'd0) begin fails++; $display("FAIL reset_wrap_cnt got=%0d exp=0", wrap_cnt); end
      tests_run++; if (first_exp !== 4'd0 || first_act !== 4'd0) begin fails++; $display("FAIL reset_first got=%0d/%0d exp=0/0", first_exp, first_act); end
      tests_run++; if (halted !== 1'b0 || h_halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%b/%b exp=0/0", halted, h_halted); end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, 4'($urandom_range(15)), 1'b0);
      e = pop_exp();
      tests_run++; if (err !== e) begin fails++; $display("FAIL idle_err got=%b exp=%b", err, e); end
      tests_run++; if (synced !== 1'b0) begin fails++; $display("FAIL idle_synced got=%b exp=0", synced); end
      tests_run++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL idle_err_cnt got=%0d exp=0", err_cnt); end
    end
  endtask

  // Returns the value the counter outputs after the sequence.
  task automatic test_count(output logic [3:0] c_out);
    logic e;
    logic [3:0] c;
    int prev;
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'($urandom_range(15)), 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL seed_err got=%b exp=%b", err, e); end
    tests_run++; if (synced !== 1'b1) begin fails++; $display("FAIL seed_synced got=%b exp=1", synced); end
    c = 4'd0;
    prev = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, c, 1'b0);
      if (prev == 15 && c == 4'd0) exp_wrap++;
      e = pop_exp();
      tests_run++; if (err !== e) begin fails++; $display("FAIL count_err i=%0d got=%b exp=%b", i, err, e); end
      tests_run++; if (synced !== 1'b1) begin fails++; $display("FAIL count_synced i=%0d got=%b exp=1", i, synced); end
      tests_run++; if (wrap_cnt !== exp_wrap[7:0]) begin fails++; $display("FAIL count_wrap i=%0d got=%0d exp=%0d", i, wrap_cnt, exp_wrap); end
      prev = int'(c);
      c = c + 4'd1;
    end
    tests_run++; if (wrap_cnt !== 8'd1) begin fails++; $display("FAIL count_wrap_total got=%0d exp=1", wrap_cnt); end
    c_out = c;
  endtask

  task automatic test_priority(input logic [3:0] c);
    logic e;
    // Reset and load together: reset must win, counter goes to 0.
    step(1'b1, 1'b0, 1'b1, 4'd9, c, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL prio_a_err got=%b exp=%b", err, e); end
    step(1'b1, 1'b1, 1'b1, 4'd9, 4'd0, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL prio_rst_err got=%b exp=%b", err, e); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL prio_load_err got=%b exp=%b", err, e); end
    tests_run++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL prio_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_inject();
    logic e;
    // Counter currently outputs 10 after the 9 sample.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd10, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL inj_seed_err got=%b exp=%b", err, e); end
    for (int v = 0; v < 5; v++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, 4'(v), 1'b0);
      e = pop_exp();
      tests_run++; if (err !== e) begin fails++; $display("FAIL inj_pre_err v=%0d got=%b exp=%b", v, err, e); end
    end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd7, 1'b1);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL inj_err got=%b exp=%b", err, e); end
    tests_run++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL inj_err_cnt got=%0d exp=1", err_cnt); end
    tests_run++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL inj_sticky got=%b exp=1", err_sticky); end
    tests_run++; if (first_exp !== 4'd5) begin fails++; $display("FAIL inj_first_exp got=%0d exp=5", first_exp); end
    tests_run++; if (first_act !== 4'd7) begin fails++; $display("FAIL inj_first_act got=%0d exp=7", first_act); end
    tests_run++; if (synced !== 1'b1 || halted !== 1'b0) begin fails++; $display("FAIL inj_state synced=%b halted=%b exp=1/0", synced, halted); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL inj_resync_err got=%b exp=%b", err, e); end
    tests_run++; if (err_cnt !== 8'd1 || err_sticky !== 1'b1) begin fails++; $display("FAIL inj_resync_cnt got=%0d/%b exp=1/1", err_cnt, err_sticky); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL inj_9_err got=%b exp=%b", err, e); end
    // Second fault: 10 expected, 3 seen. First-failure capture must hold.
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 1'b1);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL inj2_err got=%b exp=%b", err, e); end
    tests_run++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL inj2_err_cnt got=%0d exp=2", err_cnt); end
    tests_run++; if (first_exp !== 4'd5 || first_act !== 4'd7) begin fails++; $display("FAIL inj2_first got=%0d/%0d exp=5/7", first_exp, first_act); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL inj2_after_err got=%b exp=%b", err, e); end
  endtask

  task automatic test_wrap();
    logic e;
    // Counter outputs 5 now. Load 15, then increment to 0: a wrap.
    step(1'b1, 1'b1, 1'b1, 4'd15, 4'd5, 1'b0);
    e = pop_exp();
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL wrap_load_err got=%b exp=%b", err, e); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    exp_wrap++;
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL wrap_zero_err got=%b exp=%b", err, e); end
    tests_run++; if (wrap_cnt !== exp_wrap[7:0]) begin fails++; $display("FAIL wrap_load_cnt got=%0d exp=%0d", wrap_cnt, exp_wrap); end
    // Load 15, then reset to 0: not a wrap.
    step(1'b1, 1'b1, 1'b1, 4'd15, 4'd1, 1'b0);
    e = pop_exp();
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd15, 1'b0);
    e = pop_exp();
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL wrap_rst_err got=%b exp=%b", err, e); end
    tests_run++; if (wrap_cnt !== exp_wrap[7:0]) begin fails++; $display("FAIL wrap_rst_cnt got=%0d exp=%0d", wrap_cnt, exp_wrap); end
  endtask

  task automatic test_halt();
    logic e;
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    e = pop_exp();
    exp_wrap = 0;
    tests_run++; if (h_halted !== 1'b0 || h_err_cnt !== 8'd0) begin fails++; $display("FAIL halt_pre got=%b/%0d exp=0/0", h_halted, h_err_cnt); end
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    e = pop_exp();
    for (int v = 0; v < 3; v++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, 4'(v), 1'b0);
      e = pop_exp();
    end
    tests_run++; if (h_synced !== 1'b1) begin fails++; $display("FAIL halt_synced got=%b exp=1", h_synced); end
    // First fault: 3 expected, 9 seen.
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL halt_main_err got=%b exp=%b", err, e); end
    tests_run++; if (h_err !== 1'b1) begin fails++; $display("FAIL halt_err got=%b exp=1", h_err); end
    tests_run++; if (h_halted !== 1'b1 || h_synced !== 1'b0) begin fails++; $display("FAIL halt_state halted=%b synced=%b exp=1/0", h_halted, h_synced); end
    tests_run++; if (h_err_cnt !== 8'd1 || h_err_sticky !== 1'b1) begin fails++; $display("FAIL halt_cnt got=%0d/%b exp=1/1", h_err_cnt, h_err_sticky); end
    tests_run++; if (h_first_exp !== 4'd3 || h_first_act !== 4'd9) begin fails++; $display("FAIL halt_first got=%0d/%0d exp=3/9", h_first_exp, h_first_act); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd10, 1'b0);
    e = pop_exp();
    tests_run++; if (h_err !== 1'b0 || h_halted !== 1'b1) begin fails++; $display("FAIL halt_hold err=%b halted=%b exp=0/1", h_err, h_halted); end
    // Second fault: ignored while halted.
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    e = pop_exp();
    tests_run++; if (err !== e) begin fails++; $display("FAIL halt2_main_err got=%b exp=%b", err, e); end
    tests_run++; if (h_err !== 1'b0 || h_err_cnt !== 8'd1) begin fails++; $display("FAIL halt2 err=%b cnt=%0d exp=0/1", h_err, h_err_cnt); end
    tests_run++; if (h_first_exp !== 4'd3 || h_first_act !== 4'd9) begin fails++; $display("FAIL halt2_first got=%0d/%0d exp=3/9", h_first_exp, h_first_act); end
    // rst clears everything back to UNSYNC.
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
    e = pop_exp();
    tests_run++; if (h_halted !== 1'b0 || h_synced !== 1'b0) begin fails++; $display("FAIL halt_rst_state halted=%b synced=%b exp=0/0", h_halted, h_synced); end
    tests_run++; if (h_err_sticky !== 1'b0 || h_err_cnt !== 8'd0 || h_wrap_cnt !== 8'd0) begin fails++; $display("FAIL halt_rst_stats got=%b/%0d/%0d exp=0/0/0", h_err_sticky, h_err_cnt, h_wrap_cnt); end
    tests_run++; if (h_first_exp !== 4'd0 || h_first_act !== 4'd0) begin fails++; $display("FAIL halt_rst_first got=%0d/%0d exp=0/0", h_first_exp, h_first_act); end
    tests_run++; if (err_cnt !== 8'd0 || wrap_cnt !== 8'd0 || err_sticky !== 1'b0) begin fails++; $display("FAIL main_rst_stats got=%0d/%0d/%b exp=0/0/0", err_cnt, wrap_cnt, err_sticky); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0);
    e = pop_exp();
    tests_run++; if (h_synced !== 1'b0 || synced !== 1'b0) begin fails++; $display("FAIL halt_rst_unsync got=%b/%b exp=0/0", h_synced, synced); end
  endtask

  task automatic test_back_to_back();
    logic e;
    int exp_cnt;
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    e = pop_exp();
    tests_run++; if (synced !== 1'b1) begin fails++; $display("FAIL b2b_synced got=%b exp=1", synced); end
    // Constant 5 never matches: first 0 is expected, then 6 every cycle.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 1'b1);
      e = pop_exp();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      tests_run++; if (err !== e) begin fails++; $display("FAIL b2b_err i=%0d got=%b exp=%b", i, err, e); end
      tests_run++; if (err_cnt !== exp_cnt[7:0]) begin fails++; $display("FAIL b2b_cnt i=%0d got=%0d exp=%0d", i, err_cnt, exp_cnt); end
    end
    tests_run++; if (err_cnt !== 8'd255 || err_sticky !== 1'b1) begin fails++; $display("FAIL b2b_sat got=%0d/%b exp=255/1", err_cnt, err_sticky); end
    tests_run++; if (first_exp !== 4'd0 || first_act !== 4'd5) begin fails++; $display("FAIL b2b_first got=%0d/%0d exp=0/5", first_exp, first_act); end
  endtask

  initial begin
    logic [3:0] c;
    rst          = 1'b0;
    mon_rst      = 1'b1;
    mon_load     = 1'b0;
    mon_data_in  = 4'd0;
    mon_data_out = 4'd0;
    test_reset();
    test_count(c);
    test_priority(c);
    test_inject();
    test_wrap();
    test_halt();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/upcounter_checker.md
# upcounter_checker

In-fabric checker for the 4-bit up counter with load. It passively watches the counter's control inputs and its registered output. It keeps its own reference model of the next count and flags every cycle where the counter output differs from the model. It also reports error statistics, the first failing value pair, and wrap-around events, and it sits beside the counter in both the bench and the FPGA debug build.

## Interface
Parameters:
- ERR_CNT_W, 8, width of the saturating error counter
- WRAP_CNT_W, 8, width of the wrapping wrap-event counter
- STOP_ON_ERR, 0, when 1 the checker enters HALT on the first mismatch

Ports:
- clk, input, 1, single clock shared with the monitored counter
- rst, input, 1, synchronous active-low reset of the checker
- mon_rst, input, 1, counter's reset input, active-low synchronous
- mon_load, input, 1, counter's load input
- mon_data_in, input, 4, counter's load value
- mon_data_out, input, 4, counter's registered output
- synced, output, 1, reference model valid and comparison active
- err, output, 1, one-cycle mismatch pulse
- err_sticky, output, 1, set on first mismatch, cleared only by rst
- err_cnt, output, ERR_CNT_W, number of mismatches, saturating
- wrap_cnt, output, WRAP_CNT_W, number of observed 15→0 count transitions, wraps
- first_exp, output, 4, expected value at the first mismatch
- first_act, output, 4, actual value at the first mismatch
- halted, output, 1, high in HALT

## Operation
- Reference model, evaluated on the controls sampled at each clk edge, gives the counter value after that edge:
  - mon_rst=0 → 0.
  - else mon_load=1 → mon_data_in.
  - else mon_data_out+1, 4-bit, so 15→0.
- Priority: mon_rst over mon_load over increment.
- Internal exp[3:0] holds the prediction; exp_valid says it is meaningful.
- States:
  - UNSYNC, entered after rst. exp_valid=0 and no comparisons. Goes to CHECK at the first edge where mon_rst=0 or mon_load=1 is sampled, because the next value is then fully determined.
  - CHECK. At every edge, compare mon_data_out against exp, then load exp with the new prediction. Goes to HALT on mismatch if STOP_ON_ERR=1, otherwise stays in CHECK.
  - HALT. No comparisons. err_cnt, wrap_cnt, first_exp and first_act are frozen. Exit only by rst.
- Mismatch in CHECK:
  - err pulses.
  - err_sticky sets.
  - err_cnt increments, holding at its maximum value (255 by default).
  - If err_sticky was 0, first_exp←exp and first_act←mon_data_out.
- After a mismatch, the model resynchronises on the actual output. The next prediction uses mon_data_out, not exp, so one fault produces one error, not a burst.
- Wrap event, counted in CHECK only: sampled mon_data_out=15, mon_rst=1, mon_load=0, and the next sampled value equals 0 with no mismatch. Then wrap_cnt increments, modulo 2^WRAP_CNT_W.
- Loading 15 and then incrementing to 0 also counts as a wrap.
- An mon_rst-driven change from 15 to 0 is not a wrap.

## Timing
- While rst=0 is sampled, all outputs are 0 at the following edge and the state is UNSYNC. This applies mid-operation as well.
- Prediction latency: controls sampled at edge k are checked against mon_data_out sampled at edge k+1.
- err is registered. It is high for the cycle after the edge that sampled the bad value, i.e. it asserts at edge k+1 and falls at edge k+2 unless the next sample also mismatches.
- synced:
  - rises at the edge leaving UNSYNC; the first comparison happens at the following edge.
  - is high in CHECK and low in UNSYNC and HALT.
- halted rises in the same cycle as the err pulse that caused it.
- err_cnt, err_sticky, first_exp and first_act update in the same cycle as err.
- wrap_cnt updates at the edge that samples the 0.
- Back-to-back mismatches every cycle give err held high continuously, with err_cnt incrementing each cycle.

## Test plan
- rst=0 for 2 cycles, then idle with mon_rst=1, mon_load=0 and a random mon_data_out → synced=0, err=0, err_cnt=0 throughout.
- mon_rst=0 for 1 cycle, then a correct count of 20 cycles → synced=1, err never asserts, wrap_cnt=1 at the edge that samples 0 after 15.
- mon_load=1 with mon_data_in=9 at the same edge as mon_rst=0, then mon_data_out=0 → no error (reset priority). Next, load 9, then mon_data_out=9 → no error.
- Correct count, then inject mon_data_out=7 where 5 is expected → err for one cycle, err_cnt=1, first_exp=5, first_act=7. The next sample of 8 gives no error.
- STOP_ON_ERR=1 and two injected faults → halted=1 after the first, err_cnt stays 1, and rst clears everything back to UNSYNC.
- 300 consecutive mismatches → err_cnt saturates at 255 and err_sticky=1.
